// File: rtl/sdram_burst_arb_if.sv
// Handshake and status bundle between the burst arbiter (master) and the
// FIFO/sdram_top side of the SDRAM test datapath (slave).
interface sdram_burst_arb_if;
  logic [8:0]  wrf_use;
  logic [8:0]  rdf_use;
  logic        rd_enable;
  logic        sdram_wr_ack;
  logic        sdram_rd_ack;
  logic        sdram_wr_req;
  logic        sdram_rd_req;
  logic [21:0] sys_addr;
  logic [21:0] fill_words;
  logic        busy;
  logic        err_timeout;

  modport master (
    input  wrf_use, rdf_use, rd_enable, sdram_wr_ack, sdram_rd_ack,
    output sdram_wr_req, sdram_rd_req, sys_addr, fill_words, busy, err_timeout
  );

  modport slave (
    output wrf_use, rdf_use, rd_enable, sdram_wr_ack, sdram_rd_ack,
    input  sdram_wr_req, sdram_rd_req, sys_addr, fill_words, busy, err_timeout
  );
endinterface

// File: rtl/sdram_burst_arb.sv
// Round-robin scheduler of SDRAM write/read bursts over a circular region,
// tracking written-but-unread words so reads never overtake writes.
module sdram_burst_arb #(
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned FIFO_DEPTH = 256,
  parameter logic [21:0] BASE_ADDR  = 22'h000000,
  parameter logic [21:0] SPAN       = 22'h000800,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic               clk,
  input  logic               rst,
  sdram_burst_arb_if.master  bus
);

  localparam logic [21:0] BURST_W  = 22'(BURST_LEN);
  localparam logic [8:0]  BURST_U  = 9'(BURST_LEN);
  localparam logic [21:0] FILL_MAX = SPAN - BURST_W;
  localparam logic [8:0]  RDF_MAX  = 9'(FIFO_DEPTH - BURST_LEN);
  localparam int          TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_XFER,
    RD_REQ,
    RD_XFER
  } state_t;

  state_t        state_reg;
  logic [21:0]   wr_ptr_reg;
  logic [21:0]   rd_ptr_reg;
  logic [21:0]   fill_reg;
  logic [21:0]   addr_reg;
  logic [TW-1:0] timer_reg;
  logic          last_wr_reg;
  logic          wr_req_reg;
  logic          rd_req_reg;
  logic          busy_reg;
  logic          err_reg;

  logic wr_ok;
  logic rd_ok;

  assign wr_ok = (bus.wrf_use >= BURST_U) && (fill_reg <= FILL_MAX);
  assign rd_ok = bus.rd_enable && (fill_reg >= BURST_W) && (bus.rdf_use <= RDF_MAX);

  // Sum is formed one bit wider so a region ending at the top of the
  // address space still wraps correctly.
  function automatic logic [21:0] advance(input logic [21:0] ptr);
    logic [22:0] sum;
    sum = {1'b0, ptr} + {1'b0, BURST_W};
    if (sum >= ({1'b0, BASE_ADDR} + {1'b0, SPAN}))
      advance = BASE_ADDR;
    else
      advance = sum[21:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      wr_ptr_reg  <= BASE_ADDR;
      rd_ptr_reg  <= BASE_ADDR;
      fill_reg    <= '0;
      addr_reg    <= '0;
      timer_reg   <= '0;
      last_wr_reg <= 1'b0;
      wr_req_reg  <= 1'b0;
      rd_req_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          timer_reg <= '0;
          // last_wr_reg only moves on a contested grant
          if (wr_ok && (!rd_ok || !last_wr_reg)) begin
            state_reg  <= WR_REQ;
            wr_req_reg <= 1'b1;
            addr_reg   <= wr_ptr_reg;
            busy_reg   <= 1'b1;
            if (rd_ok)
              last_wr_reg <= 1'b1;
          end else if (rd_ok) begin
            state_reg  <= RD_REQ;
            rd_req_reg <= 1'b1;
            addr_reg   <= rd_ptr_reg;
            busy_reg   <= 1'b1;
            if (wr_ok)
              last_wr_reg <= 1'b0;
          end
        end

        WR_REQ: begin
          if (bus.sdram_wr_ack) begin
            state_reg  <= WR_XFER;
            wr_req_reg <= 1'b0;
          end else if (timer_reg == TIMER_LAST) begin
            state_reg  <= IDLE;
            wr_req_reg <= 1'b0;
            busy_reg   <= 1'b0;
            err_reg    <= 1'b1;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        WR_XFER: begin
          if (!bus.sdram_wr_ack) begin
            state_reg  <= IDLE;
            busy_reg   <= 1'b0;
            wr_ptr_reg <= advance(wr_ptr_reg);
            fill_reg   <= fill_reg + BURST_W;
          end
        end

        RD_REQ: begin
          if (bus.sdram_rd_ack) begin
            state_reg  <= RD_XFER;
            rd_req_reg <= 1'b0;
          end else if (timer_reg == TIMER_LAST) begin
            state_reg  <= IDLE;
            rd_req_reg <= 1'b0;
            busy_reg   <= 1'b0;
            err_reg    <= 1'b1;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        RD_XFER: begin
          if (!bus.sdram_rd_ack) begin
            state_reg  <= IDLE;
            busy_reg   <= 1'b0;
            rd_ptr_reg <= advance(rd_ptr_reg);
            fill_reg   <= fill_reg - BURST_W;
          end
        end

        default: begin
          state_reg  <= IDLE;
          wr_req_reg <= 1'b0;
          rd_req_reg <= 1'b0;
          busy_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sdram_wr_req = wr_req_reg;
  assign bus.sdram_rd_req = rd_req_reg;
  assign bus.sys_addr     = addr_reg;
  assign bus.fill_words   = fill_reg;
  assign bus.busy         = busy_reg;
  assign bus.err_timeout  = err_reg;

endmodule

// File: tb/tb_sdram_burst_arb.sv
// Directed bench for sdram_burst_arb: a default-parameter instance and a
// small wrapping instance, each answered by a simple sdram_top ack model.
module tb_sdram_burst_arb;

  localparam int TIMEOUT = 1023;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_burst_arb_if bus0 ();
  sdram_burst_arb_if bus1 ();

  sdram_burst_arb u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  sdram_burst_arb #(
    .BASE_ADDR (22'h000100),
    .SPAN      (22'h000010)
  ) u_small (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // Stimulus goes to the selected instance; the other one sees idle inputs.
  logic       sel;
  logic [8:0] wrf;
  logic [8:0] rdf;
  logic       rd_en;
  logic       ack_en;

  assign bus0.wrf_use   = sel ? 9'd0 : wrf;
  assign bus0.rdf_use   = sel ? 9'd0 : rdf;
  assign bus0.rd_enable = sel ? 1'b0 : rd_en;
  assign bus1.wrf_use   = sel ? wrf : 9'd0;
  assign bus1.rdf_use   = sel ? rdf : 9'd0;
  assign bus1.rd_enable = sel ? rd_en : 1'b0;

  logic        cur_wr_req, cur_rd_req, cur_busy, cur_err;
  logic [21:0] cur_addr, cur_fill;
  assign cur_wr_req = sel ? bus1.sdram_wr_req : bus0.sdram_wr_req;
  assign cur_rd_req = sel ? bus1.sdram_rd_req : bus0.sdram_rd_req;
  assign cur_busy   = sel ? bus1.busy         : bus0.busy;
  assign cur_err    = sel ? bus1.err_timeout  : bus0.err_timeout;
  assign cur_addr   = sel ? bus1.sys_addr     : bus0.sys_addr;
  assign cur_fill   = sel ? bus1.fill_words   : bus0.fill_words;

  logic req_w [2];
  logic req_r [2];
  assign req_w[0] = bus0.sdram_wr_req;
  assign req_r[0] = bus0.sdram_rd_req;
  assign req_w[1] = bus1.sdram_wr_req;
  assign req_r[1] = bus1.sdram_rd_req;

  // sdram_top model: ack rises 2 cycles after req is seen, stays high 8 cycles.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      int   dly;
      int   len;
      logic wa;
      logic ra;
      always @(posedge clk) begin
        if (rst) begin
          wa  <= 1'b0;
          ra  <= 1'b0;
          dly <= 0;
          len <= 0;
        end else if (len != 0) begin
          len <= len - 1;
          if (len == 1) begin
            wa <= 1'b0;
            ra <= 1'b0;
          end
        end else if (ack_en && (req_w[gi] || req_r[gi])) begin
          if (dly == 1) begin
            dly <= 0;
            len <= 8;
            wa  <= req_w[gi];
            ra  <= req_r[gi];
          end else begin
            dly <= dly + 1;
          end
        end else begin
          dly <= 0;
        end
      end
    end
  endgenerate

  assign bus0.sdram_wr_ack = g_resp[0].wa;
  assign bus0.sdram_rd_ack = g_resp[0].ra;
  assign bus1.sdram_wr_ack = g_resp[1].wa;
  assign bus1.sdram_rd_ack = g_resp[1].ra;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // kind: 0 = no request expected, 1 = write burst, 2 = read burst
  typedef struct {
    bit          sel;
    logic [8:0]  wrf;
    logic [8:0]  rdf;
    bit          rd_en;
    int          kind;
    logic [21:0] addr;
    logic [21:0] fill;
  } vec_t;

  vec_t vecs [19];

  task automatic quiesce();
    wrf   = 9'd0;
    rdf   = 9'd0;
    rd_en = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int n;
    int kind;
    sel   = vecs[i].sel;
    wrf   = vecs[i].wrf;
    rdf   = vecs[i].rdf;
    rd_en = vecs[i].rd_en;
    n = 0;
    while (!(cur_wr_req || cur_rd_req) && n < 20) begin
      @(negedge clk);
      n++;
    end
    kind = {30'd0, cur_rd_req, cur_wr_req};
    check($sformatf("vec%0d_kind", i), kind, vecs[i].kind);
    if (kind != 0) begin
      check($sformatf("vec%0d_busy", i), {31'd0, cur_busy}, 32'd1);
      check($sformatf("vec%0d_addr", i), {10'd0, cur_addr}, {10'd0, vecs[i].addr});
      n = 0;
      while (cur_busy && n < 64) begin
        @(negedge clk);
        n++;
      end
      quiesce();
      check($sformatf("vec%0d_done", i), {31'd0, cur_busy}, 32'd0);
    end else begin
      quiesce();
    end
    check($sformatf("vec%0d_fill", i), {10'd0, cur_fill}, {10'd0, vecs[i].fill});
    $display("vec %0d: sel=%0d kind=%0d addr=0x%0h fill=%0d", i, sel, kind, cur_addr, cur_fill);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_req"}, {31'd0, bus0.sdram_wr_req}, 32'd0);
    check({tag, "_rd_req"}, {31'd0, bus0.sdram_rd_req}, 32'd0);
    check({tag, "_addr"},   {10'd0, bus0.sys_addr},     32'd0);
    check({tag, "_fill"},   {10'd0, bus0.fill_words},   32'd0);
    check({tag, "_busy"},   {31'd0, bus0.busy},         32'd0);
    check({tag, "_err"},    {31'd0, bus0.err_timeout},  32'd0);
  endtask

  initial begin
    int n;
    //           sel   wrf     rdf      rd   kind addr        fill
    vecs[0]  = '{1'b0, 9'd0,  9'd0,   1'b1, 0, 22'h000,  22'd0};
    vecs[1]  = '{1'b0, 9'd8,  9'd0,   1'b0, 1, 22'h000,  22'd8};
    vecs[2]  = '{1'b0, 9'd16, 9'd0,   1'b1, 1, 22'h008,  22'd16};
    vecs[3]  = '{1'b0, 9'd16, 9'd0,   1'b1, 2, 22'h000,  22'd8};
    vecs[4]  = '{1'b0, 9'd16, 9'd0,   1'b1, 1, 22'h010,  22'd16};
    vecs[5]  = '{1'b0, 9'd0,  9'd0,   1'b1, 2, 22'h008,  22'd8};
    vecs[6]  = '{1'b0, 9'd0,  9'd249, 1'b1, 0, 22'h000,  22'd8};
    vecs[7]  = '{1'b0, 9'd0,  9'd248, 1'b1, 2, 22'h010,  22'd0};
    vecs[8]  = '{1'b0, 9'd7,  9'd0,   1'b1, 0, 22'h000,  22'd0};
    vecs[9]  = '{1'b0, 9'd8,  9'd0,   1'b1, 1, 22'h018,  22'd8};
    vecs[10] = '{1'b0, 9'd8,  9'd0,   1'b0, 1, 22'h020,  22'd16};
    vecs[11] = '{1'b0, 9'd8,  9'd0,   1'b0, 1, 22'h000,  22'd8};
    vecs[12] = '{1'b0, 9'd0,  9'd0,   1'b1, 2, 22'h000,  22'd0};
    vecs[13] = '{1'b1, 9'd8,  9'd0,   1'b0, 1, 22'h100,  22'd8};
    vecs[14] = '{1'b1, 9'd8,  9'd0,   1'b0, 1, 22'h108,  22'd16};
    vecs[15] = '{1'b1, 9'd8,  9'd0,   1'b0, 0, 22'h000,  22'd16};
    vecs[16] = '{1'b1, 9'd0,  9'd0,   1'b1, 2, 22'h100,  22'd8};
    vecs[17] = '{1'b1, 9'd8,  9'd0,   1'b0, 1, 22'h100,  22'd16};
    vecs[18] = '{1'b1, 9'd0,  9'd0,   1'b1, 2, 22'h108,  22'd8};

    rst    = 1'b1;
    sel    = 1'b0;
    ack_en = 1'b1;
    quiesce();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i <= 9; i++) run_vec(i);

    // Ack withheld: the write request must give up after TIMEOUT cycles.
    ack_en = 1'b0;
    sel    = 1'b0;
    wrf    = 9'd8;
    n = 0;
    while (!cur_wr_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("to_req_seen", {31'd0, cur_wr_req}, 32'd1);
    check("to_addr", {10'd0, cur_addr}, 32'h20);
    n = 0;
    while (cur_wr_req && n < TIMEOUT + 10) begin
      n++;
      @(negedge clk);
    end
    quiesce();
    check("to_req_cycles", n, TIMEOUT);
    check("to_err", {31'd0, cur_err}, 32'd1);
    check("to_busy", {31'd0, cur_busy}, 32'd0);
    check("to_fill", {10'd0, cur_fill}, 32'd8);
    $display("timeout: req high %0d cycles err=%0d fill=%0d", n, cur_err, cur_fill);
    ack_en = 1'b1;
    @(negedge clk);
    run_vec(10);
    check("to_err_sticky", {31'd0, cur_err}, 32'd1);

    // Reset pulsed while the write burst is in its transfer phase.
    wrf = 9'd8;
    n = 0;
    while (!(bus0.sdram_wr_ack && !cur_wr_req && cur_busy) && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("rst_in_xfer", {31'd0, bus0.sdram_wr_ack}, 32'd1);
    rst = 1'b1;
    quiesce();
    @(negedge clk);
    check_reset_outputs("midrst");
    $display("reset mid-burst: busy=%0d fill=%0d err=%0d", bus0.busy, bus0.fill_words, bus0.err_timeout);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 11; i <= 18; i++) run_vec(i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
